// File: rtl/mem_preloader_pkg.sv
// Shared encodings and width defaults for the boot-time memory preloader.
package mem_preloader_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned REG_WIDTH  = 8;

    typedef enum logic [1:0] {
        PRELOAD_FILL   = 2'd0,
        PRELOAD_LOAD   = 2'd1,
        PRELOAD_VERIFY = 2'd2,
        PRELOAD_BOOT   = 2'd3
    } preload_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_VRD   = 3'd3,
        ST_VWAIT = 3'd4,
        ST_VCMP  = 3'd5,
        ST_BOOT  = 3'd6,
        ST_RUN   = 3'd7
    } preload_state_e;

endpackage

// File: rtl/mem_preloader_addr_gen.sv
// Loadable base/count address generator with modulo wrap; shared by FILL, LOAD and VERIFY.
module preload_addr_gen #(
    parameter int unsigned ADDR_WIDTH = mem_preloader_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [ADDR_WIDTH-1:0] load_cnt,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  done_c,
    output logic                  last_c
);

    logic [ADDR_WIDTH-1:0] cnt_q;

    // addr is the next word to touch, cnt_q the words still outstanding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            addr  <= load_addr;
            cnt_q <= load_cnt;
        end else if (step) begin
            addr  <= addr + ADDR_WIDTH'(1);
            cnt_q <= cnt_q - ADDR_WIDTH'(1);
        end
    end

    assign done_c = (cnt_q == '0);
    assign last_c = (cnt_q == ADDR_WIDTH'(1));

endmodule

// File: rtl/mem_preloader.sv
// Boot-time memory loader: runs fill/load/verify commands on the shared memory, then releases the core.
module mem_preloader #(
    parameter int unsigned ADDR_WIDTH  = mem_preloader_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = mem_preloader_pkg::REG_WIDTH,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned TRIG_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_fill,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_own,
    output logic                  core_reset_n,
    output logic                  trigger,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    import mem_preloader_pkg::*;

    localparam int unsigned WAIT_W = 2;
    localparam int unsigned TRIG_W = 4;

    preload_state_e        state_q, state_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [TRIG_W-1:0]     trig_q, trig_d;

    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic                  mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic                  mem_own_d;
    logic                  core_reset_n_d;
    logic                  trigger_d;
    logic                  err_d;
    logic [ADDR_WIDTH-1:0] err_addr_d;

    logic                  gen_load;
    logic                  gen_step;
    logic [ADDR_WIDTH-1:0] gen_load_addr;
    logic [ADDR_WIDTH-1:0] gen_load_cnt;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_done;
    logic                  gen_last;

    preload_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (gen_load),
        .step      (gen_step),
        .load_addr (gen_load_addr),
        .load_cnt  (gen_load_cnt),
        .addr      (gen_addr),
        .done_c    (gen_done),
        .last_c    (gen_last)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign s_ready   = ((state_q == ST_LOAD) && !gen_done) || (state_q == ST_VCMP);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_RUN);

    always_comb begin
        state_d        = state_q;
        fill_d         = fill_q;
        wait_d         = wait_q;
        trig_d         = trig_q;
        mem_addr_d     = mem_addr;
        mem_we_d       = 1'b0;
        mem_wdata_d    = mem_wdata;
        mem_own_d      = mem_own;
        core_reset_n_d = core_reset_n;
        trigger_d      = 1'b0;
        err_d          = err;
        err_addr_d     = err_addr;
        gen_load       = 1'b0;
        gen_step       = 1'b0;
        gen_load_addr  = cmd_base;
        gen_load_cnt   = cmd_len;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    fill_d = cmd_fill;
                    case (preload_mode_e'(cmd_mode))
                        PRELOAD_FILL: begin
                            state_d  = ST_FILL;
                            gen_load = 1'b1;
                            // First word goes out on the accept edge so writes are back to back
                            if (cmd_len != '0) begin
                                mem_addr_d    = cmd_base;
                                mem_we_d      = 1'b1;
                                mem_wdata_d   = cmd_fill;
                                gen_load_addr = cmd_base + ADDR_WIDTH'(1);
                                gen_load_cnt  = cmd_len - ADDR_WIDTH'(1);
                            end
                        end
                        PRELOAD_LOAD: begin
                            state_d  = ST_LOAD;
                            gen_load = 1'b1;
                        end
                        PRELOAD_VERIFY: begin
                            state_d  = ST_VRD;
                            gen_load = 1'b1;
                        end
                        default: begin
                            state_d = ST_BOOT;
                            if (!err) begin
                                mem_own_d      = 1'b0;
                                core_reset_n_d = 1'b1;
                                trigger_d      = 1'b1;
                                trig_d         = TRIG_W'(TRIG_CYCLES - 1);
                            end
                        end
                    endcase
                end
            end
            ST_FILL: begin
                if (gen_done) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_addr_d  = gen_addr;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = fill_q;
                    gen_step    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (gen_done) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    mem_addr_d  = gen_addr;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = s_data;
                    gen_step    = 1'b1;
                    if (gen_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_VRD: begin
                if (gen_done) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_addr_d = gen_addr;
                    wait_d     = WAIT_W'(RD_LAT - 1);
                    state_d    = ST_VWAIT;
                end
            end
            ST_VWAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_VCMP;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_VCMP: begin
                // mem_addr is held since VRD, so mem_rdata stays valid while waiting on the stream
                if (s_valid) begin
                    if (s_data != mem_rdata) begin
                        if (!err) begin
                            err_d      = 1'b1;
                            err_addr_d = gen_addr;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        gen_step = 1'b1;
                        state_d  = gen_last ? ST_IDLE : ST_VRD;
                    end
                end
            end
            ST_BOOT: begin
                if (err) begin
                    state_d = ST_IDLE;
                end else if (trig_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    trig_d    = trig_q - TRIG_W'(1);
                    trigger_d = 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            fill_q       <= '0;
            wait_q       <= '0;
            trig_q       <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            mem_own      <= 1'b1;
            core_reset_n <= 1'b0;
            trigger      <= 1'b0;
            err          <= 1'b0;
            err_addr     <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            wait_q       <= wait_d;
            trig_q       <= trig_d;
            mem_addr     <= mem_addr_d;
            mem_we       <= mem_we_d;
            mem_wdata    <= mem_wdata_d;
            mem_own      <= mem_own_d;
            core_reset_n <= core_reset_n_d;
            trigger      <= trigger_d;
            err          <= err_d;
            err_addr     <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_preloader.sv
// Scoreboard bench for mem_preloader: expected writes queued by stimulus, checked by a write monitor.
module tb_mem_preloader;

    import mem_preloader_pkg::*;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned RDL  = 1;
    localparam int unsigned TRIG = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [AW-1:0] cmd_base;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] cmd_fill;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_own;
    logic          core_reset_n;
    logic          trigger;
    logic          busy;
    logic          err;
    logic [AW-1:0] err_addr;

    mem_preloader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RD_LAT      (RDL),
        .TRIG_CYCLES (TRIG)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .cmd_fill     (cmd_fill),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_own      (mem_own),
        .core_reset_n (core_reset_n),
        .trigger      (trigger),
        .busy         (busy),
        .err          (err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    // Memory model with RDL-cycle registered read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [RDL];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < int'(RDL); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RDL-1];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Write monitor: every mem_we cycle must match the head of the expected queue
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write", {8'h0, mem_addr, mem_wdata}, {8'h0, mon_e.addr, mon_e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic [AW-1:0] base,
                            input logic [AW-1:0] len, input logic [DW-1:0] fill);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("cmd_ready_wait");
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_base  = base;
        cmd_len   = len;
        cmd_fill  = fill;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic stream(input logic [DW-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("s_ready_wait");
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("idle_wait");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bad;
        logic saw_trig;
        logic saw_rel;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = '0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_fill  = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) tick();
        check("reset_mem", {mem_addr, mem_we, mem_wdata}, '0);
        check("reset_ctrl", {mem_own, core_reset_n, trigger, err}, 4'b1000);
        check("reset_err_addr", err_addr, 0);
        reset_n = 1'b1;
        tick();
        check("post_reset_ready", {cmd_ready, busy}, 2'b10);

        // 1: FILL 16 words of A5 from 0x0000
        for (int i = 0; i < 16; i++) push_wr(AW'(i), 8'hA5);
        send_cmd(PRELOAD_FILL, 16'h0000, 16'h0010, 8'hA5);
        cyc = 1;
        while (!cmd_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check("fill_ready_cycle", cyc, 17);
        check("fill_all_written", exp_q.size(), 0);

        // 2: LOAD with a stream gap after the second word
        push_wr(16'h8000, 8'h11);
        push_wr(16'h8001, 8'h22);
        push_wr(16'h8002, 8'h33);
        push_wr(16'h8003, 8'h44);
        send_cmd(PRELOAD_LOAD, 16'h8000, 16'h0004, 8'h00);
        stream(8'h11);
        stream(8'h22);
        s_data = 8'hEE;
        repeat (3) tick();
        stream(8'h33);
        stream(8'h44);
        wait_idle();
        tick();
        check("load_all_written", exp_q.size(), 0);

        // 3: VERIFY with a mismatch on the third word, then a refused BOOT
        send_cmd(PRELOAD_VERIFY, 16'h8000, 16'h0004, 8'h00);
        stream(8'h11);
        stream(8'h22);
        stream(8'h99);
        wait_idle();
        check("verify_err", err, 1);
        check("verify_err_addr", err_addr, 32'h8002);
        check("verify_idle", {cmd_ready, busy}, 2'b10);
        send_cmd(PRELOAD_BOOT, 16'h0000, 16'h0000, 8'h00);
        saw_trig = 1'b0;
        saw_rel  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            saw_trig |= trigger;
            saw_rel  |= core_reset_n;
            tick();
        end
        check("boot_refused", {saw_trig, saw_rel, mem_own, cmd_ready}, 4'b0011);

        // 4: FILL wrapping past the top of the address space
        push_wr(16'hFFFE, 8'h5A);
        push_wr(16'hFFFF, 8'h5A);
        push_wr(16'h0000, 8'h5A);
        send_cmd(PRELOAD_FILL, 16'hFFFE, 16'h0003, 8'h5A);
        wait_idle();
        tick();
        check("wrap_all_written", exp_q.size(), 0);

        // 6: reset in the middle of a LOAD clears outputs and the sticky error
        push_wr(16'h4000, 8'hC1);
        push_wr(16'h4001, 8'hC2);
        send_cmd(PRELOAD_LOAD, 16'h4000, 16'h0004, 8'h00);
        stream(8'hC1);
        stream(8'hC2);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {mem_we, core_reset_n, err, mem_own}, 4'b0001);
        check("midreset_err_addr", err_addr, 0);
        check("midreset_written", exp_q.size(), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("midreset_ready", {cmd_ready, busy}, 2'b10);
        push_wr(16'h0100, 8'h3C);
        push_wr(16'h0101, 8'h3C);
        send_cmd(PRELOAD_FILL, 16'h0100, 16'h0002, 8'h3C);
        wait_idle();
        tick();
        check("refill_all_written", exp_q.size(), 0);

        // 5: clean LOAD, VERIFY, BOOT, then RUN must hold
        push_wr(16'h2000, 8'h01);
        push_wr(16'h2001, 8'h02);
        push_wr(16'h2002, 8'h03);
        send_cmd(PRELOAD_LOAD, 16'h2000, 16'h0003, 8'h00);
        stream(8'h01);
        stream(8'h02);
        stream(8'h03);
        wait_idle();
        tick();
        check("clean_load_written", exp_q.size(), 0);
        send_cmd(PRELOAD_VERIFY, 16'h2000, 16'h0003, 8'h00);
        stream(8'h01);
        stream(8'h02);
        stream(8'h03);
        wait_idle();
        check("clean_verify_err", err, 0);
        send_cmd(PRELOAD_BOOT, 16'h0000, 16'h0000, 8'h00);
        check("boot_first_cycle", {core_reset_n, trigger, mem_own, mem_we}, 4'b1100);
        tick();
        check("boot_trigger_done", {trigger, busy, core_reset_n}, 3'b001);
        bad = 0;
        cmd_valid = 1'b1;
        cmd_mode  = PRELOAD_FILL;
        cmd_len   = 16'h0004;
        s_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready || s_ready || trigger || !core_reset_n || mem_own || mem_we) bad++;
            tick();
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        check("run_hold", bad, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_preloader.md
Name: mem_preloader

Overview:
- Boot-time memory loader and core-release controller. It owns the memory port while the core is held in reset.
- It executes a queue of commands:
  - zero/constant fill of an address region;
  - streamed program load;
  - readback verify against an expected stream;
  - boot, which hands the memory to the core, releases core reset and pulses the program trigger.
- Sits between the top-level test/boot interface and the shared memory. It is the parametrised replacement for ad-hoc manual memory muxing and trigger sequencing.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory word width.
- RD_LAT, 1, memory read latency in clk cycles (1..4).
- TRIG_CYCLES, 1, width of the trigger pulse in cycles (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_mode  in  2  0=FILL, 1=LOAD, 2=VERIFY, 3=BOOT.
- cmd_base  in  ADDR_WIDTH  first address.
- cmd_len  in  ADDR_WIDTH  word count; 0 = no-op.
- cmd_fill  in  DATA_WIDTH  FILL constant.
- s_valid  in  1  stream word valid (LOAD data / VERIFY expected).
- s_ready  out  1  stream word accepted this cycle.
- s_data  in  DATA_WIDTH  stream word.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid RD_LAT cycles after address.
- mem_own  out  1  loader owns memory; top level muxes on this.
- core_reset_n  out  1  core reset, active low.
- trigger  out  1  program-start pulse.
- busy  out  1  not IDLE and not RUN.
- err  out  1  sticky verify mismatch.
- err_addr  out  ADDR_WIDTH  address of first mismatch.

Behaviour:
- Reset (async, any state including mid-command):
  - state=IDLE.
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - mem_own=1, core_reset_n=0, trigger=0.
  - err=0, err_addr=0.
  - Internal address and count registers = 0.
  - An in-flight command is abandoned; no partial-state recovery.
- After reset deasserts: cmd_ready=1, busy=0.
- Command handshake: accepted on cmd_valid&&cmd_ready. Base, len and fill are latched; cmd_ready drops the next cycle.
- cmd_len=0: the FSM returns to IDLE the next cycle with no memory access.
- Addresses increment modulo 2^ADDR_WIDTH. Region 16'hFFFF len 2 touches FFFF then 0000.
- FILL: one write per cycle, mem_we=1, mem_wdata=fill, for len cycles. Returns to IDLE the cycle after the last write.
- LOAD:
  - s_ready=1 in the LOAD state.
  - Each s_valid&&s_ready cycle registers one write (mem_we=1 the following cycle at the current address).
  - Gaps in s_valid stall without writing.
  - Returns to IDLE after len words.
- VERIFY, non-pipelined per word:
  - VRD drives mem_addr and mem_we=0.
  - VWAIT holds for RD_LAT cycles.
  - VCMP asserts s_ready and waits for s_valid.
  - Compare: on mismatch, err is set (if not already set), err_addr is captured and the FSM returns to IDLE immediately. On match, it advances.
  - Per-word latency is RD_LAT+2 cycles minimum.
- BOOT:
  - If err=1: the command is accepted and the FSM returns to IDLE; core stays in reset.
  - Otherwise: mem_own=0, mem_we=0 and core_reset_n=1 on the cycle after accept.
  - trigger=1 for TRIG_CYCLES cycles starting the same cycle, then the FSM enters RUN.
- RUN: terminal; cmd_ready=0, s_ready=0, core_reset_n=1, mem_own=0. Exit only via reset_n.
- s_ready=0 outside LOAD and VCMP. Stream words presented then are not consumed.
- All outputs are registered except cmd_ready, s_ready and busy, which decode from state.

Decomposition:
- Shared package holds the mode encodings (PRELOAD_FILL, PRELOAD_LOAD, PRELOAD_VERIFY, PRELOAD_BOOT) and the FSM state encodings for IDLE, FILL, LOAD, VRD, VWAIT, VCMP, BOOT, RUN.
- Width defaults reuse the existing ADDR_WIDTH/REG_WIDTH package defines.
- One natural sub-module: preload_addr_gen, a loadable base/count address generator with modulo wrap and a done flag. It is shared by FILL, LOAD and VERIFY.

Test Plan:
1. Reset, then FILL base=0x0000 len=0x10 fill=0xA5 -> 16 writes at 0x0000..0x000F on consecutive cycles, data A5; cmd_ready returns 1 on cycle 17 after accept.
2. LOAD base=0x8000 len=4, stream 11,22,33,44 with an s_valid gap after 22 -> writes 8000=11, 8001=22, 8002=33, 8003=44; no write during the gap.
3. VERIFY base=0x8000 len=4, expected 11,22,99,44, RD_LAT=1 -> err=1, err_addr=0x8002, FSM in IDLE; a following BOOT leaves core_reset_n=0 and trigger=0.
4. FILL base=0xFFFE len=3 -> writes at FFFE, FFFF, 0000 (wrap).
5. Clean LOAD, then VERIFY, then BOOT with TRIG_CYCLES=1 -> core_reset_n rises and trigger=1 for exactly one cycle; mem_own=0; cmd_ready stays 0 for 100 cycles.
6. Assert reset_n low mid-LOAD after 2 of 4 words -> immediately mem_we=0, core_reset_n=0, err=0; after release, cmd_ready=1 and a new FILL executes normally.
